serial_addsub_ctrl: RTL
=======================

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port sub, input, 1, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a, input, WIDTH, first operand, two's complement or unsigned; sampled with start.
REQ-007 SHALL have port b, input, WIDTH, second operand; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while the operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a completed result.
REQ-010 SHALL have port result, output, WIDTH, sum/difference.
REQ-011 SHALL have port cout, output, 1, final carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 SHALL have port ovf, output, 1, signed overflow flag.

Function
REQ-013 SHALL evaluate one bit per cycle, LSB first, through a single full-adder cell: sum = a^b'^c, carry = majority(a,b',c), where b' = b^sub.
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE with start=1, capture a, b and sub into internal shift registers, set the carry flip-flop to sub, clear the bit counter, and enter RUN.
REQ-016 SHALL, in RUN, process bit[counter] each cycle, shift its sum bit into the result register MSB-side, update the carry flip-flop, and increment the counter.
REQ-017 SHALL leave RUN after exactly WIDTH cycles (counter = WIDTH-1 processed) and enter DONE.
REQ-018 SHALL assert done for exactly the single DONE cycle, then return to IDLE, unless REQ-022 applies.
REQ-019 SHALL assert busy in RUN only; busy SHALL be 0 in IDLE and DONE.
REQ-020 SHALL give a latency such that, with start sampled at edge t, done is high in the cycle after edge t+WIDTH.
REQ-021 SHALL ignore start while busy=1; captured operands are unaffected by input changes after capture.
REQ-022 SHALL accept start in the DONE cycle: done still pulses, the new operands are captured, and the FSM enters RUN (back-to-back throughput of WIDTH+1 cycles).
REQ-023 SHALL hold result, cout and ovf stable from the DONE cycle until the next accepted start.
REQ-024 SHALL not update result, cout or ovf while in RUN; they hold the previous values until DONE.
REQ-025 SHALL compute ovf = (carry into MSB) XOR (carry out of MSB).
REQ-026 SHALL discard all wrap beyond WIDTH bits; the result is modulo 2^WIDTH.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force IDLE, busy=0, done=0, result=0, cout=0, ovf=0, and clear the counter and the carry flip-flop.
REQ-028 SHALL give rst priority over start, including when both are high in the same cycle.
REQ-029 SHALL, on reset mid-RUN, abandon the operation with no done pulse; the next start after rst is released operates normally.

Verification (WIDTH=8)
REQ-030 SHALL cover: start, sub=0, a=0x7F, b=0x01 -> busy for 8 cycles, done 9 cycles after start, result=0x80, cout=0, ovf=1.
REQ-031 SHALL cover: sub=1, a=0x05, b=0x07 -> result=0xFE, cout=0, ovf=0; sub=1, a=0x80, b=0x01 -> result=0x7F, cout=1, ovf=1.
REQ-032 SHALL cover: sub=0, a=0xFF, b=0x01 -> result=0x00, cout=1, ovf=0.
REQ-033 SHALL cover: start pulsed at cycles 3 and 5 of RUN with different operands -> ignored; the original result is delivered at the normal time.
REQ-034 SHALL cover: start held high through the DONE cycle -> done pulses once, the second operation is captured, and its done follows 9 cycles later.
REQ-035 SHALL cover: rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, result=0, and no done pulse follows.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell evaluated LSB first, WIDTH
// cycles per operation, with a start/busy/done handshake around it.
module serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic            sub_r, carry;
  logic [CW-1:0]   cnt;
  logic            accept, last;
  logic            bit_a, bit_b, sum_bit, carry_nxt;

  assign last      = (cnt == CW'(WIDTH - 1));
  assign bit_a     = a_sh[0];
  assign bit_b     = b_sh[0] ^ sub_r;
  assign sum_bit   = bit_a ^ bit_b ^ carry;
  assign carry_nxt = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The a shift register doubles as the sum accumulator: each consumed
  // operand bit leaves the LSB while its sum bit enters at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sub_r  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        sub_r <= sub;
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= {sum_bit, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
        carry <= carry_nxt;
        cnt   <= cnt + CW'(1);
        if (last) begin
          result <= {sum_bit, a_sh[WIDTH-1:1]};
          cout   <= carry_nxt;
          ovf    <= carry ^ carry_nxt;
        end
      end
    end
  end

endmodule
